// File: rtl/input_sram_reader.sv
// input_sram_reader: streams a burst of 64-bit words from the input SRAM controller through a small FIFO.
// Optional macro INPUT_SRAM_READER_STRIDE_EN adds a per-burst address stride port.
module input_sram_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] length,
`ifdef INPUT_SRAM_READER_STRIDE_EN
   input  logic [LEN_W-1:0] stride,
`endif
   output logic             busy,
   output logic             done,
   output logic             r_en,
   output logic [31:0]      r_addr,
   input  logic [63:0]      r_d,
   input  logic             d_ready,
   output logic             out_valid,
   output logic [63:0]      out_data,
   input  logic             out_ready
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t             state, state_n;
   logic [31:0]        addr, addr_n, r_addr_n, step;
   logic [LEN_W-1:0]   remaining, remaining_n;
   logic               r_en_n, done_n, busy_n;
   logic [63:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push, pop;

`ifdef INPUT_SRAM_READER_STRIDE_EN
   logic [LEN_W-1:0]   stride_q, stride_n;
   assign step = 32'(stride_q);
`else
   assign step = 32'd1;
`endif

   assign push      = (state == WAIT) && d_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // State and registered controller-side outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         r_en      <= 1'b0;
         r_addr    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
`ifdef INPUT_SRAM_READER_STRIDE_EN
         stride_q  <= '0;
`endif
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         remaining <= remaining_n;
         r_en      <= r_en_n;
         r_addr    <= r_addr_n;
         done      <= done_n;
         busy      <= busy_n;
`ifdef INPUT_SRAM_READER_STRIDE_EN
         stride_q  <= stride_n;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      remaining_n = remaining;
      r_en_n      = 1'b0;
      r_addr_n    = r_addr;
      done_n      = 1'b0;
`ifdef INPUT_SRAM_READER_STRIDE_EN
      stride_n    = stride_q;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  addr_n      = base_addr;
                  remaining_n = length;
`ifdef INPUT_SRAM_READER_STRIDE_EN
                  stride_n    = stride;
`endif
                  state_n     = ISSUE;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         ISSUE: begin
            // A free slot now guarantees room for the single outstanding word
            if (count < CNT_W'(FIFO_DEPTH)) begin
               r_en_n   = 1'b1;
               r_addr_n = addr;
               state_n  = WAIT;
            end
         end
         WAIT: begin
            if (d_ready) begin
               remaining_n = remaining - LEN_W'(1);
               addr_n      = addr + step;
               state_n     = (remaining == LEN_W'(1)) ? DRAIN : ISSUE;
            end
         end
         DRAIN: begin
            if (count == '0) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= r_d;
   end

endmodule

// File: tb/tb_input_sram_reader.sv
// Bench for input_sram_reader: random-latency SRAM responder, random consumer, queue-based reference.
// Build with +define+INPUT_SRAM_READER_STRIDE_EN to also cover the stride option.
module tb_input_sram_reader;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned LEN_W      = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      base_addr = '0;
   logic [LEN_W-1:0] length = '0;
`ifdef INPUT_SRAM_READER_STRIDE_EN
   logic [LEN_W-1:0] stride = '0;
`endif
   logic             busy, done, r_en;
   logic [31:0]      r_addr;
   logic [63:0]      r_d = '0;
   logic             d_ready = 1'b0;
   logic             out_valid;
   logic [63:0]      out_data;
   logic             out_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd_addrs[$];
   logic [63:0] sent[$];
   logic [63:0] got[$];
   int  rd_cnt = 0, done_cnt = 0, viol = 0, cnt = 0;
   int  lat_min = 1, lat_max = 1, rdy_mode = 0;
   bit  busy_seen = 0, outstanding = 0, stale = 0;

   input_sram_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
`ifdef INPUT_SRAM_READER_STRIDE_EN
      .stride(stride),
`endif
      .busy(busy), .done(done), .r_en(r_en), .r_addr(r_addr), .r_d(r_d), .d_ready(d_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clock = ~clock;

   // Reference address: base + i*step, wrapping at 2^32
   function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i, input logic [LEN_W-1:0] s);
      return b + 32'(i) * 32'(s);
   endfunction

   // Consumer: out_ready driven just after the rising edge
   initial begin
      forever begin
         @(posedge clock); #1;
         if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
         else               out_ready = (rdy_mode == 0);
      end
   end

   // Monitor + SRAM responder: samples on the falling edge, answers each read after lat_min..lat_max cycles
   initial begin
      forever begin
         @(negedge clock);
         if (done) done_cnt++;
         if (busy) busy_seen = 1;
         if (out_valid && out_ready) got.push_back(out_data);
         d_ready = 1'b0;
         r_d = {$urandom, $urandom};
         if (reset && outstanding) stale = 1;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               d_ready = 1'b1;
               r_d = {$urandom, $urandom};
               if (!stale) sent.push_back(r_d);
               stale = 0;
               outstanding = 0;
            end
         end
         if (r_en && !reset) begin
            rd_addrs.push_back(r_addr);
            rd_cnt++;
            if (outstanding) viol++;
            outstanding = 1;
            cnt = $urandom_range(lat_max, lat_min);
         end
      end
   end

   // Runs one burst; returns to = 1 if done never arrived
   task automatic do_burst(input logic [31:0] b, input int len, input logic [LEN_W-1:0] s,
                           input bit poke, output bit to);
      int d0;
      rd_addrs.delete(); sent.delete(); got.delete();
      d0 = done_cnt;
      base_addr = b;
      length = LEN_W'(len);
`ifdef INPUT_SRAM_READER_STRIDE_EN
      stride = s;
`endif
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      base_addr = $urandom;
      length = LEN_W'($urandom_range(1, 7));
      to = 1;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt != d0) begin to = 0; break; end
         start = poke && busy && ($urandom_range(0, 3) == 0);
         @(posedge clock); #1;
      end
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      int d0;
      bit to;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (r_en !== 1'b0)     begin errors++; $display("FAIL reset_r_en got=%b exp=0", r_en); end
      checks++; if (r_addr !== 32'h0)  begin errors++; $display("FAIL reset_r_addr got=%h exp=0", r_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      // start presented for the very first edge after release
      rd_addrs.delete(); sent.delete(); got.delete();
      d0 = done_cnt;
      @(negedge clock);
      reset = 1'b0; base_addr = 32'h40; length = LEN_W'(1); start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_start_busy got=%b exp=1", busy); end
      to = 1;
      for (int i = 0; i < 200; i++) begin
         if (done_cnt != d0) begin to = 0; break; end
         @(posedge clock); #1;
      end
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL first_start_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 1 || rd_addrs[0] !== 32'h40)
         begin errors++; $display("FAIL first_start_addr got_n=%0d exp 1 read at 00000040", rd_addrs.size()); end
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_basic();
      bit to;
      int d0;
      lat_min = 1; lat_max = 1; rdy_mode = 0;
      d0 = done_cnt;
      do_burst(32'h100, 3, LEN_W'(1), 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 3) begin errors++; $display("FAIL basic_reads got=%0d exp=3", rd_addrs.size()); end
      for (int i = 0; i < rd_addrs.size() && i < 3; i++) begin
         checks++;
         if (rd_addrs[i] !== exp_addr(32'h100, i, LEN_W'(1)))
            begin errors++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, rd_addrs[i], exp_addr(32'h100, i, LEN_W'(1))); end
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL basic_words got=%0d exp=3", got.size()); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         checks++;
         if (got[i] !== sent[i]) begin errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_cycles got=%0d exp=1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_zero_len();
      int d0, r0;
      d0 = done_cnt; r0 = rd_cnt; busy_seen = 0;
      base_addr = 32'h500; length = '0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_cycles got=%0d exp=1", done_cnt - d0); end
      checks++; if (rd_cnt - r0 != 0)   begin errors++; $display("FAIL zero_reads got=%0d exp=0", rd_cnt - r0); end
      checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy_seen); end
   endtask

   task automatic test_backpressure();
      logic [31:0] b;
      int d0, r0;
      bit to;
      b = $urandom;
      lat_min = 1; lat_max = 3; rdy_mode = 2;
      repeat (2) @(posedge clock);
      #1;
      rd_addrs.delete(); sent.delete(); got.delete();
      d0 = done_cnt; r0 = rd_cnt;
      base_addr = b; length = LEN_W'(6);
`ifdef INPUT_SRAM_READER_STRIDE_EN
      stride = LEN_W'(1);
`endif
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (60) @(posedge clock);
      #1;
      checks++; if (rd_cnt - r0 != FIFO_DEPTH) begin errors++; $display("FAIL bp_stalled_reads got=%0d exp=%0d", rd_cnt - r0, FIFO_DEPTH); end
      checks++; if (r_en !== 1'b0)      begin errors++; $display("FAIL bp_r_en got=%b exp=0", r_en); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
      rdy_mode = 0;
      to = 1;
      for (int i = 0; i < 500; i++) begin
         if (done_cnt != d0) begin to = 0; break; end
         @(posedge clock); #1;
      end
      repeat (2) @(posedge clock);
      #1;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 6) begin errors++; $display("FAIL bp_reads got=%0d exp=6", rd_addrs.size()); end
      for (int i = 0; i < rd_addrs.size() && i < 6; i++) begin
         checks++;
         if (rd_addrs[i] !== exp_addr(b, i, LEN_W'(1)))
            begin errors++; $display("FAIL bp_addr[%0d] got=%h exp=%h", i, rd_addrs[i], exp_addr(b, i, LEN_W'(1))); end
      end
      checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_words got=%0d exp=6", got.size()); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         checks++;
         if (got[i] !== sent[i]) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_wrap();
      bit to;
      lat_min = 1; lat_max = 2; rdy_mode = 0;
      do_burst(32'hFFFF_FFFF, 2, LEN_W'(1), 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrap_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 2) begin errors++; $display("FAIL wrap_reads got=%0d exp=2", rd_addrs.size()); end
      if (rd_addrs.size() == 2) begin
         checks++; if (rd_addrs[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=ffffffff", rd_addrs[0]); end
         checks++; if (rd_addrs[1] !== 32'h0)         begin errors++; $display("FAIL wrap_addr1 got=%h exp=00000000", rd_addrs[1]); end
      end
   endtask

   task automatic test_random();
      logic [31:0]      b;
      logic [LEN_W-1:0] s;
      int len, d0;
      bit to;
      lat_min = 1; lat_max = 4; rdy_mode = 1;
      for (int n = 0; n < 12; n++) begin
         b = $urandom;
         len = $urandom_range(1, 10);
`ifdef INPUT_SRAM_READER_STRIDE_EN
         s = LEN_W'($urandom_range(0, 7));
`else
         s = LEN_W'(1);
`endif
         d0 = done_cnt;
         do_burst(b, len, s, 1, to);
         checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got=%b exp=0", n, to); end
         checks++; if (rd_addrs.size() != len) begin errors++; $display("FAIL rnd%0d_reads got=%0d exp=%0d", n, rd_addrs.size(), len); end
         for (int i = 0; i < rd_addrs.size() && i < len; i++) begin
            checks++;
            if (rd_addrs[i] !== exp_addr(b, i, s))
               begin errors++; $display("FAIL rnd%0d_addr[%0d] got=%h exp=%h", n, i, rd_addrs[i], exp_addr(b, i, s)); end
         end
         checks++; if (got.size() != len) begin errors++; $display("FAIL rnd%0d_words got=%0d exp=%0d", n, got.size(), len); end
         for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin errors++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", n, i, got[i], sent[i]); end
         end
         checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd%0d_done got=%0d exp=1", n, done_cnt - d0); end
      end
      checks++; if (viol != 0) begin errors++; $display("FAIL outstanding_reads got=%0d exp=0", viol); end
   endtask

   task automatic test_reset_mid_burst();
      bit to;
      lat_min = 4; lat_max = 4; rdy_mode = 2;
      repeat (2) @(posedge clock);
      #1;
      rd_addrs.delete(); sent.delete(); got.delete();
      base_addr = 32'h200; length = LEN_W'(5);
`ifdef INPUT_SRAM_READER_STRIDE_EN
      stride = LEN_W'(1);
`endif
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      to = 1;
      for (int i = 0; i < 200; i++) begin
         if (rd_addrs.size() == 3) begin to = 0; break; end
         @(posedge clock); #1;
      end
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL mid_third_read_timeout got=%b exp=0", to); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got=%b exp=1", out_valid); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      checks++; if (r_en !== 1'b0)      begin errors++; $display("FAIL mid_rst_r_en got=%b exp=0", r_en); end
      checks++; if (r_addr !== 32'h0)   begin errors++; $display("FAIL mid_rst_r_addr got=%h exp=0", r_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
      @(posedge clock); #1;
      reset = 1'b0;
      rdy_mode = 0;
      repeat (8) @(posedge clock);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_d_ready_pushed got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL late_busy got=%b exp=0", busy); end
      lat_min = 1; lat_max = 2;
      do_burst(32'h300, 3, LEN_W'(1), 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL post_rst_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 3) begin errors++; $display("FAIL post_rst_reads got=%0d exp=3", rd_addrs.size()); end
      for (int i = 0; i < rd_addrs.size() && i < 3; i++) begin
         checks++;
         if (rd_addrs[i] !== exp_addr(32'h300, i, LEN_W'(1)))
            begin errors++; $display("FAIL post_rst_addr[%0d] got=%h exp=%h", i, rd_addrs[i], exp_addr(32'h300, i, LEN_W'(1))); end
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL post_rst_words got=%0d exp=3", got.size()); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         checks++;
         if (got[i] !== sent[i]) begin errors++; $display("FAIL post_rst_data[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
   endtask

`ifdef INPUT_SRAM_READER_STRIDE_EN
   task automatic test_stride();
      bit to;
      lat_min = 1; lat_max = 3; rdy_mode = 0;
      do_burst(32'h10, 3, LEN_W'(4), 0, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL stride_timeout got=%b exp=0", to); end
      checks++; if (rd_addrs.size() != 3) begin errors++; $display("FAIL stride_reads got=%0d exp=3", rd_addrs.size()); end
      for (int i = 0; i < rd_addrs.size() && i < 3; i++) begin
         checks++;
         if (rd_addrs[i] !== 32'h10 + 32'(4 * i))
            begin errors++; $display("FAIL stride_addr[%0d] got=%h exp=%h", i, rd_addrs[i], 32'h10 + 32'(4 * i)); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_wrap();
      test_random();
      test_reset_mid_burst();
`ifdef INPUT_SRAM_READER_STRIDE_EN
      test_stride();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/input_sram_reader.md
INPUT_SRAM_READER -- requirements
Module: input_sram_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in 64-bit words (power of two, 2..16).
REQ-002 SHALL have parameter LEN_W, default 16, width of the length and stride inputs.
REQ-003 SHALL have the ports listed below. There is one clock. Reset is asynchronous and active-high.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  in  32  word address of the first read.
- length  in  LEN_W  number of 64-bit words to fetch.
- stride  in  LEN_W  address increment per word; present only with the REQ-019 macro.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- r_en  out  1  read request to the input SRAM controller.
- r_addr  out  32  read word address.
- r_d  in  64  read data from the controller.
- d_ready  in  1  read data valid from the controller.
- out_valid  out  1  stream data valid.
- out_data  out  64  stream data.
- out_ready  in  1  stream consumer accepts the word.

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, WAIT and DRAIN.
REQ-005 IDLE behaviour:
- start=1 and length!=0: latch base_addr, length (and stride), then go to ISSUE.
- start=1 and length==0: pulse done on the next cycle and stay in IDLE.
- start=0: stay in IDLE.
REQ-006 ISSUE SHALL assert r_en, with r_addr equal to the current address, only when fifo_count < FIFO_DEPTH. When that holds, go to WAIT; otherwise hold r_en low and stay in ISSUE.
REQ-007 r_en and r_addr SHALL be registered outputs. r_en SHALL be high for exactly one cycle per word, and only one read SHALL be outstanding at any time.
REQ-008 WAIT behaviour on d_ready=1:
- push r_d into the FIFO;
- decrement the remaining count;
- advance the address;
- go to DRAIN if remaining becomes 0, otherwise go to ISSUE.
REQ-009 The block SHALL tolerate any d_ready latency of one or more cycles after the r_en cycle. d_ready seen outside WAIT SHALL be ignored.
REQ-010 The address SHALL advance by 1 per word (by stride when the REQ-019 macro is defined) and SHALL wrap modulo 2^32. The block performs no range check.
REQ-011 DRAIN SHALL wait until the FIFO is empty, then pulse done for one cycle and return to IDLE.
REQ-012 FIFO behaviour:
- first-in first-out;
- out_valid = (fifo_count != 0);
- out_data = the head entry;
- a pop occurs when out_valid and out_ready are both high.
REQ-013 A simultaneous push and pop SHALL leave fifo_count unchanged. A push into a full FIFO is impossible by construction, per REQ-006.
REQ-014 start asserted while busy=1 SHALL be ignored.
REQ-015 The block SHALL never write to the controller; it performs reads only.

Reset
REQ-016 reset=1 SHALL asynchronously force the following, and hold them while asserted:
- state = IDLE;
- busy = 0, done = 0, r_en = 0, r_addr = 0, out_valid = 0;
- FIFO pointers and count = 0;
- remaining count = 0.
REQ-017 A reset asserted mid-burst SHALL abandon the burst and discard the FIFO contents. A d_ready arriving after reset release SHALL be ignored.
REQ-018 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-019 Macro INPUT_SRAM_READER_STRIDE_EN:
- defined: the stride port exists and is latched at start; the address advances by stride (stride = 0 re-reads the same word).
- undefined: no stride port; the address advances by 1.

Verification
REQ-020 Reset, base_addr=0x100, length=3, out_ready=1, d_ready one cycle after each r_en -> r_addr 0x100, 0x101, 0x102; 3 words output in order; one done pulse; busy returns to 0.
REQ-021 length=0 with start -> no r_en; done high for exactly one cycle; busy stays 0.
REQ-022 length=6, out_ready=0 -> exactly 4 r_en pulses, then r_en stays low and out_valid=1. Raising out_ready -> the remaining 2 reads issue and all 6 words arrive in order.
REQ-023 base_addr=0xFFFFFFFF, length=2 -> r_addr 0xFFFFFFFF, then 0x00000000.
REQ-024 Reset asserted in WAIT with 2 words buffered -> outputs reach reset values immediately; a late d_ready pushes nothing; a new burst then completes normally.
REQ-025 With INPUT_SRAM_READER_STRIDE_EN defined: base_addr=0x10, stride=4, length=3 -> r_addr 0x10, 0x14, 0x18.
